// File: rtl/led_bank_driver_pkg.sv
// Shared mode encoding and defaults for the LED bank driver.
// LED_BREATHE_EN selects whether mode 2 decodes as BREATHE or falls back to COUNT.
package led_bank_driver_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_STATIC  = 2'd3
    } mode_e;

    localparam int LED_BANK_W = 8;

    function automatic mode_e decode_mode(input mode_e raw);
`ifdef LED_BREATHE_EN
        return raw;
`else
        return (raw == MODE_BREATHE) ? MODE_COUNT : raw;
`endif
    endfunction

endpackage

// File: rtl/led_bank_driver_switch_debounce.sv
// Two-flop synchroniser followed by a two-sample agreement filter per bit.
// The sample tick comes from outside so the whole panel shares one timebase.
module switch_debounce #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] samp_q,  samp_d;
    logic [WIDTH-1:0] deb_q,   deb_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        samp_d  = sample_tick ? sync2_q : samp_q;
    end

    // A bit only moves when the current sample repeats the previous one.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign deb_d[gi] = (sample_tick && (sync2_q[gi] == samp_q[gi])) ? sync2_q[gi]
                                                                       : deb_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/led_bank_driver.sv
// Multi-bank LED driver: free-running counter feeding COUNT/CHASE/BREATHE/STATIC patterns,
// each masked by debounced DIP switches. BREATHE PWM logic is built only with LED_BREATHE_EN.
module led_bank_driver
    import led_bank_driver_pkg::*;
#(
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = LED_BANK_W,
    parameter int CNT_W     = 32,
    parameter int PWM_W     = 8,
    parameter int STEP_LOG2 = 22,
    parameter int DB_LOG2   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS*BANK_W-1:0]   dsw,
    input  logic [1:0]                    mode,
    input  logic                          hold,
    output logic [NUM_BANKS*BANK_W-1:0]   lb
);

    localparam int LEDS  = NUM_BANKS * BANK_W;
    localparam int POS_W = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(LEDS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       mode_s1_q, mode_s1_d;
    logic [1:0]       mode_s2_q, mode_s2_d;
    mode_e            mode_q, mode_d, mode_eff;
    logic [LEDS-1:0]  lb_q, lb_d;
    logic [LEDS-1:0]  mask, count_pat, chase_pat;
    logic             db_tick, step_tick, mode_chg;

    // Both ticks derive from cnt, so hold also stalls debounce and chase.
    assign db_tick   = (&cnt_q[DB_LOG2-1:0]) && !hold;
    assign step_tick = (&cnt_q[STEP_LOG2-1:0]) && !hold;

    switch_debounce #(
        .WIDTH (LEDS)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (db_tick),
        .din         (dsw),
        .dout        (mask)
    );

    always_comb begin
        cnt_d     = hold ? cnt_q : cnt_q + CNT_W'(1);
        mode_s1_d = mode;
        mode_s2_d = mode_s1_q;
        mode_d    = mode_e'(mode_s2_q);
        mode_chg  = (mode_d != mode_q);
        mode_eff  = decode_mode(mode_q);
    end

    // A mode change restarts the chase even when a step tick lands on the same clock.
    always_comb begin
        pos_d = pos_q;
        if (mode_chg) begin
            pos_d = '0;
        end else if (step_tick) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign count_pat[gi*BANK_W +: BANK_W] = cnt_q[CNT_W-1 -: BANK_W] & mask[gi*BANK_W +: BANK_W];
    end

    assign chase_pat = (LEDS'(1) << pos_q) & mask;

`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] phase;
    logic [PWM_W-1:0] duty;
    logic [PWM_W:0]   tri_t;
    logic             pwm_on;

    // Triangle duty: rising for the first half of t, mirrored for the second.
    always_comb begin
        phase  = cnt_q[PWM_W-1:0];
        tri_t  = cnt_q[CNT_W-1 -: PWM_W+1];
        duty   = tri_t[PWM_W] ? ~tri_t[PWM_W-1:0] : tri_t[PWM_W-1:0];
        pwm_on = (phase < duty);
    end
`endif

    always_comb begin
        lb_d = count_pat;
        case (mode_eff)
            MODE_CHASE:   lb_d = chase_pat;
            MODE_STATIC:  lb_d = mask;
`ifdef LED_BREATHE_EN
            MODE_BREATHE: lb_d = pwm_on ? mask : '0;
`endif
            default:      lb_d = count_pat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            mode_s1_q <= '0;
            mode_s2_q <= '0;
            mode_q    <= MODE_COUNT;
            lb_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            mode_s1_q <= mode_s1_d;
            mode_s2_q <= mode_s2_d;
            mode_q    <= mode_d;
            lb_q      <= lb_d;
        end
    end

    assign lb = lb_q;

endmodule

// File: tb/tb_led_bank_driver.sv
// Directed bench for led_bank_driver with a small reference model of cnt/pos/mode sync.
// Uses a 12-bit counter so wrap and both BREATHE windows fit in a short run.
module tb_led_bank_driver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] dsw;
    logic [1:0]  mode;
    logic        hold;
    logic [23:0] lb;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [11:0] m_cnt, m_used;
    logic [4:0]  m_pos;
    logic [1:0]  m_s1, m_s2, m_mode;
    logic [23:0] m_exp, m_mask, prev_lb, frozen;
    bit          wrapped, seen_top, found, changed;

    led_bank_driver #(
        .NUM_BANKS (3),
        .BANK_W    (8),
        .CNT_W     (12),
        .PWM_W     (4),
        .STEP_LOG2 (2),
        .DB_LOG2   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsw   (dsw),
        .mode  (mode),
        .hold  (hold),
        .lb    (lb)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_lb(input logic [11:0] c, input logic [4:0] p,
                                           input logic [1:0] md, input logic [23:0] mk);
`ifdef LED_BREATHE_EN
        logic [4:0] t;
        logic [3:0] duty;
`endif
        case (md)
            2'd1: return (24'd1 << p) & mk;
            2'd3: return mk;
`ifdef LED_BREATHE_EN
            2'd2: begin
                t    = c[11:7];
                duty = t[4] ? ~t[3:0] : t[3:0];
                return (c[3:0] < duty) ? mk : 24'd0;
            end
`endif
            default: return {3{c[11:4]}} & mk;
        endcase
    endfunction

    // Reference model: lb is registered from the previous cnt/pos/mode.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= '0;
            m_used <= '0;
            m_pos  <= '0;
            m_s1   <= '0;
            m_s2   <= '0;
            m_mode <= '0;
            m_exp  <= '0;
        end else begin
            m_used <= m_cnt;
            m_exp  <= exp_lb(m_cnt, m_pos, m_mode, m_mask);
            if (!hold) m_cnt <= m_cnt + 12'd1;
            m_s1   <= mode;
            m_s2   <= m_s1;
            m_mode <= m_s2;
            if (m_s2 != m_mode)
                m_pos <= '0;
            else if (!hold && m_cnt[1:0] == 2'b11)
                m_pos <= (m_pos == 5'd23) ? 5'd0 : m_pos + 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chk_en) chk("model", 32'(lb), 32'(m_exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dsw    = '1;
        mode   = 2'd0;
        hold   = 1'b0;
        m_mask = '0;
        #1 rst_n = 1'b0;
        #1 chk("rst_lb", 32'(lb), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(1);
        chk("post_rst", 32'(lb), 32'd0);
        run(20);
        m_mask = '1;
        chk_en = 1'b1;

        // COUNT: banks follow cnt[11:4], then zero after wrap
        wrapped  = 1'b0;
        seen_top = 1'b0;
        for (int i = 0; i < 4300 && !wrapped; i++) begin
            run(1);
            if (seen_top && m_used == 12'd0) begin
                chk("wrap_zero", 32'(lb), 32'd0);
                wrapped = 1'b1;
            end else begin
                chk("count", 32'(lb), 32'({3{m_used[11:4]}}));
            end
            if (m_used == 12'hFFF) seen_top = 1'b1;
        end
        chk("wrap_seen", 32'(wrapped), 32'd1);

        // one-clock glitch on dsw[0] must not reach the mask
        dsw[0] = 1'b0;
        run(1);
        dsw[0] = 1'b1;
        repeat (16) begin
            run(1);
            chk("glitch", 32'(lb), 32'({3{m_used[11:4]}}));
        end
        dsw[0] = 1'b0;
        chk_en = 1'b0;
        run(16);
        m_mask[0] = 1'b0;
        chk_en = 1'b1;
        repeat (16) begin
            run(1);
            chk("dsw0_off", 32'(lb), 32'({3{m_used[11:4]}} & 24'hFFFFFE));
        end
        dsw[0] = 1'b1;
        chk_en = 1'b0;
        run(16);
        m_mask = '1;
        chk_en = 1'b1;

        // CHASE: one-hot rotating left through 24 bits
        mode = 2'd1;
        run(6);
        repeat (110) begin
            prev_lb = lb;
            run(1);
            chk("onehot", 32'($countones(lb)), 32'd1);
            if (lb != prev_lb) chk("advance", 32'(lb), 32'({prev_lb[22:0], prev_lb[23]}));
        end
        mode = 2'd3;
        run(4);
        chk("static", 32'(lb), 32'h00FF_FFFF);
        run(4);
        mode = 2'd1;
        run(4);
        chk("restart", 32'(lb), 32'd1);

        // hold freezes the chase
        run(3);
        hold = 1'b1;
        run(1);
        frozen = lb;
        repeat (19) begin
            run(1);
            chk("hold", 32'(lb), 32'(frozen));
        end
        hold = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 6 && !changed; i++) begin
            run(1);
            if (lb != frozen) changed = 1'b1;
        end
        chk("resume", 32'(changed), 32'd1);

        // mode 2: BREATHE when built, COUNT otherwise
        mode = 2'd2;
        run(4);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            run(1);
            if (m_used[11:7] == 5'b00011 && m_used[3:0] == 4'd0) found = 1'b1;
        end
        chk("win3_found", 32'(found), 32'd1);
        for (int ph = 0; ph < 16; ph++) begin
`ifdef LED_BREATHE_EN
            chk("breathe3", 32'(lb), (ph < 3) ? 32'h00FF_FFFF : 32'd0);
`else
            chk("m2count", 32'(lb), 32'({3{m_used[11:4]}}));
`endif
            run(1);
        end
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            run(1);
            if (m_used[11:7] == 5'b10000 && m_used[3:0] == 4'd0) found = 1'b1;
        end
        chk("win15_found", 32'(found), 32'd1);
        for (int ph = 0; ph < 16; ph++) begin
`ifdef LED_BREATHE_EN
            chk("breathe15", 32'(lb), (ph < 15) ? 32'h00FF_FFFF : 32'd0);
`else
            chk("m2count", 32'(lb), 32'({3{m_used[11:4]}}));
`endif
            run(1);
        end

        // asynchronous reset pulse mid-CHASE, between clock edges
        mode = 2'd1;
        run(10);
        #1 rst_n = 1'b0;
        m_mask = '0;
        chk_en = 1'b0;
        #1 chk("async_rst", 32'(lb), 32'd0);
        #1 rst_n = 1'b1;
        run(1);
        chk("rst_resume0", 32'(lb), 32'd0);
        run(1);
        chk("rst_resume1", 32'(lb), 32'd0);
        run(20);
        m_mask = '1;
        chk_en = 1'b1;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
